// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, command bytes, default timings.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StRts     = 3'd1,
    StReq     = 3'd2,
    StStart   = 3'd3,
    StData    = 3'd4,
    StAck     = 3'd5,
    StRelease = 3'd6
  } tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_ACK          = 8'hFA;
  localparam logic [7:0] PS2_BREAK        = 8'hF0;

  // 100 us inhibit and 15 ms ACK timeout at 50 MHz
  localparam int unsigned PS2_INHIBIT_CYC = 5000;
  localparam int unsigned PS2_TIMEOUT_CYC = 750000;
  localparam int unsigned PS2_FILTER_LEN  = 8;

  // Odd parity above the data byte, LSB shifted out first
  function automatic logic [8:0] ps2_frame(input logic [7:0] data);
    return {~^data, data};
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchroniser plus debounce filter for a PS/2 line; emits a one-cycle pulse on a filtered fall.
module ps2_clk_filter #(
  parameter int unsigned FilterLen = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic fall_o
);

  localparam int unsigned CntW = (FilterLen > 1) ? $clog2(FilterLen) : 1;

  logic [1:0]      sync_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            fall_q, fall_d;

  // Level flips only after FilterLen consecutive samples disagree with it
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntW'(FilterLen - 1)) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    fall_d = level_q & ~level_d;
  end

  // Synchroniser, filter state and fall pulse; idle bus reads high
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-clock frame, ACK check, timeout.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYC = PS2_INHIBIT_CYC,
  parameter int unsigned TIMEOUT_CYC = PS2_TIMEOUT_CYC,
  parameter int unsigned FILTER_LEN  = PS2_FILTER_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_busy,
  output logic       tx_done_tick,
  output logic       tx_err_tick
);

  localparam int unsigned CntMax = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  tx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [8:0]      sr_q, sr_d;
  logic [3:0]      bit_q, bit_d;
  logic            ack_q, ack_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic c_level, c_fall;
  logic d_level, d_fall;
  logic unused_d_fall;

  ps2_clk_filter #(.FilterLen(FILTER_LEN)) u_clk_filter (
    .clk_i   (clk),
    .rst_i   (reset),
    .raw_i   (ps2c_in),
    .level_o (c_level),
    .fall_o  (c_fall)
  );

  // Same filter on the data line so the ACK sample is glitch-free
  ps2_clk_filter #(.FilterLen(FILTER_LEN)) u_dat_filter (
    .clk_i   (clk),
    .rst_i   (reset),
    .raw_i   (ps2d_in),
    .level_o (d_level),
    .fall_o  (d_fall)
  );

  assign unused_d_fall = d_fall;

  // Next-state logic; one counter serves both the inhibit period and the ACK timeout
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    ack_d   = ack_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (wr_ps2) begin
          sr_d    = ps2_frame(din);
          cnt_d   = '0;
          state_d = StRts;
        end
      end
      StRts: begin
        if (cnt_q == CntW'(INHIBIT_CYC - 1)) begin
          cnt_d   = '0;
          state_d = StReq;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StReq: begin
        cnt_d   = '0;
        state_d = StStart;
      end
      StStart: begin
        cnt_d = cnt_q + 1'b1;
        if (c_fall) begin
          bit_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        cnt_d = cnt_q + 1'b1;
        if (c_fall) begin
          // bit_q == 8 means parity is on the wire; this fall releases data for the stop bit
          if (bit_q == 4'd8) begin
            state_d = StAck;
          end else begin
            sr_d  = {1'b1, sr_q[8:1]};
            bit_d = bit_q + 1'b1;
          end
        end
      end
      StAck: begin
        cnt_d = cnt_q + 1'b1;
        if (c_fall) begin
          ack_d   = ~d_level;
          state_d = StRelease;
        end
      end
      StRelease: begin
        cnt_d = cnt_q + 1'b1;
        if (c_level && d_level) begin
          done_d  = ack_q;
          err_d   = ~ack_q;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Timeout overrides any progress made in the device-clocked states
    if ((state_q inside {StStart, StData, StAck, StRelease}) &&
        (cnt_q == CntW'(TIMEOUT_CYC - 1))) begin
      done_d  = 1'b0;
      err_d   = 1'b1;
      state_d = StIdle;
    end
  end

  // State, counters and registered completion ticks
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sr_q    <= '1;
      bit_q   <= '0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Moore output decode from registered state and shift register LSB
  always_comb begin
    tx_busy      = (state_q != StIdle);
    ps2c_oe      = (state_q == StRts) || (state_q == StReq);
    ps2d_oe      = (state_q == StReq) || (state_q == StStart) ||
                   ((state_q == StData) && !sr_q[0]);
    tx_done_tick = done_q;
    tx_err_tick  = err_q;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench: open-drain bus with a behavioural keyboard and frame/tick scoreboards.
module tb_ps2_host_tx;

  localparam int unsigned Inhibit = 5000;
  localparam int unsigned Timeout = 4000;
  localparam int          Half    = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_ps2;
  logic [7:0] din;
  logic       ps2c_oe, ps2d_oe;
  logic       tx_busy, tx_done_tick, tx_err_tick;
  logic       dev_c, dev_d;
  logic       ps2c_line, ps2d_line;

  int n_cmp = 0;
  int n_err = 0;

  logic [10:0] frame_q[$];
  logic [1:0]  tick_q[$];
  logic        prev_tick = 1'b0;

  assign ps2c_line = ~ps2c_oe & dev_c;
  assign ps2d_line = ~ps2d_oe & dev_d;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYC (Inhibit),
    .TIMEOUT_CYC (Timeout),
    .FILTER_LEN  (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_ps2       (wr_ps2),
    .din          (din),
    .ps2c_in      (ps2c_line),
    .ps2d_in      (ps2d_line),
    .ps2c_oe      (ps2c_oe),
    .ps2d_oe      (ps2d_oe),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick),
    .tx_err_tick  (tx_err_tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Tick scoreboard: every tick must match the next queued outcome (2'b10 done, 2'b01 err)
  always @(negedge clk) begin
    if (tx_done_tick || tx_err_tick) begin
      if (tick_q.size() == 0) check("tick_unexpected", {tx_done_tick, tx_err_tick}, 2'b00);
      else check("tick_kind", {tx_done_tick, tx_err_tick}, tick_q.pop_front());
      check("busy_at_tick", tx_busy, 1'b0);
      check("tick_width", prev_tick, 1'b0);
    end
    prev_tick = tx_done_tick | tx_err_tick;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] d, input bit exp_frame, input logic [1:0] outcome);
    @(negedge clk);
    din    = d;
    wr_ps2 = 1'b1;
    if (exp_frame) frame_q.push_back({1'b1, ~^d, d, 1'b0});
    if (outcome != 2'b00) tick_q.push_back(outcome);
    @(negedge clk);
    wr_ps2 = 1'b0;
    din    = 8'($urandom);
  endtask

  // Measures the inhibit and start-request phases, returns at the first cycle clock is released
  task automatic wait_release(output logic start_bit);
    int guard = 0;
    int inh   = 0;
    int rq    = 0;
    while (!ps2c_oe && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    guard = 0;
    while (ps2c_oe && guard < 20000) begin
      if (ps2d_oe) rq++;
      else inh++;
      @(negedge clk);
      guard++;
    end
    check("rts_released", ps2c_oe, 1'b0);
    check("inhibit_cycles", inh, Inhibit);
    check("req_cycles", rq, 1);
    start_bit = ps2d_line;
  endtask

  // One device clock: high half (optionally with a 3-cycle glitch), low half, sample on the rise
  task automatic clk_pulse(input bit glitch, output logic b);
    if (glitch) begin
      repeat (Half / 2) @(negedge clk);
      dev_c = 1'b0;
      repeat (3) @(negedge clk);
      dev_c = 1'b1;
      repeat (Half - Half / 2 - 3) @(negedge clk);
    end else begin
      repeat (Half) @(negedge clk);
    end
    dev_c = 1'b0;
    repeat (Half) @(negedge clk);
    dev_c = 1'b1;
    b = ps2d_line;
  endtask

  task automatic dev_frame(input bit nack, input int glitch_at, input int wr_at);
    logic [10:0] got;
    logic        sb;
    logic        dummy;
    wait_release(sb);
    got[0] = sb;
    for (int i = 1; i <= 10; i++) begin
      if (i == wr_at) begin
        wr_ps2 = 1'b1;
        din    = 8'h00;
        @(negedge clk);
        wr_ps2 = 1'b0;
      end
      clk_pulse(i == glitch_at, got[i]);
    end
    if (!nack) dev_d = 1'b0;
    clk_pulse(1'b0, dummy);
    repeat (Half) @(negedge clk);
    dev_d = 1'b1;
    if (frame_q.size() == 0) check("frame_expected", 1'b0, 1'b1);
    else check("frame_bits", got, frame_q.pop_front());
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((tx_busy || tick_q.size() != 0) && g < 20000) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    check("idle_busy", tx_busy, 1'b0);
    check("tick_pending", tick_q.size(), 0);
  endtask

  initial begin
    logic sb;
    logic b;
    int   n;
    reset  = 1'b1;
    wr_ps2 = 1'b0;
    din    = 8'h00;
    dev_c  = 1'b1;
    dev_d  = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;

    // Quiet idle after reset
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_outputs", {ps2c_oe, ps2d_oe, tx_busy, tx_done_tick, tx_err_tick}, 5'b0);
    end

    // 0xED with device ACK
    send(PS2_CMD_SET_LEDS_TB(), 1'b1, 2'b10);
    dev_frame(1'b0, 0, 0);
    wait_idle();

    // 0xED with device NACK
    send(8'hED, 1'b1, 2'b01);
    dev_frame(1'b1, 0, 0);
    wait_idle();

    // Device never clocks: timeout measured from clock release
    send(8'hED, 1'b0, 2'b01);
    wait_release(sb);
    n = 0;
    while (!(tx_err_tick || tx_done_tick) && n < int'(Timeout) + 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", n, Timeout);
    check("timeout_err", tx_err_tick, 1'b1);
    check("timeout_oe", {ps2c_oe, ps2d_oe}, 2'b00);
    wait_idle();

    // 0xFF completes normally, with a short ps2c glitch during data bits
    send(8'hFF, 1'b1, 2'b10);
    dev_frame(1'b0, 5, 0);
    wait_idle();

    // Write of 0x00 during data must be ignored
    send(8'hED, 1'b1, 2'b10);
    dev_frame(1'b0, 0, 4);
    wait_idle();

    // Reset mid-frame at data bit 4
    send(8'hED, 1'b0, 2'b00);
    wait_release(sb);
    for (int i = 1; i <= 4; i++) clk_pulse(1'b0, b);
    check("busy_mid_frame", tx_busy, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_release", {ps2c_oe, ps2d_oe, tx_busy}, 3'b000);

    // Reset and write in the same cycle: reset wins
    @(negedge clk);
    reset  = 1'b1;
    wr_ps2 = 1'b1;
    din    = 8'hED;
    @(negedge clk);
    reset  = 1'b0;
    wr_ps2 = 1'b0;
    check("reset_vs_wr", tx_busy, 1'b0);
    @(negedge clk);
    check("reset_vs_wr_after", {ps2c_oe, tx_busy}, 2'b00);

    repeat (50) @(negedge clk);
    check("frames_left", frame_q.size(), 0);
    check("ticks_left", tick_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  function automatic logic [7:0] PS2_CMD_SET_LEDS_TB();
    return 8'hED;
  endfunction

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends one command byte (e.g. 8'hED set-LEDs, 8'hFF reset) from the host to the keyboard over the shared open-drain ps2c/ps2d lines. It is the send direction of the PS/2 keyboard interface and sits beside the receive path and the F0 break-code FSM. tx_busy lets the receive path ignore bus activity while a frame is being sent.

Parameters:
INHIBIT_CYC, 5000, clk cycles ps2c is held low for request-to-send (100 us at 50 MHz)
TIMEOUT_CYC, 750000, max clk cycles from clock release to ACK (15 ms at 50 MHz)
FILTER_LEN, 8, number of consecutive equal ps2c samples needed to change the filtered level

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
wr_ps2  in  1  one-cycle start strobe; sampled only in idle
din  in  8  byte to send; captured when wr_ps2 is accepted
ps2c_in  in  1  PS/2 clock line, read back
ps2d_in  in  1  PS/2 data line, read back
ps2c_oe  out  1  1 = pull ps2c low; 0 = release (pad is open-drain)
ps2d_oe  out  1  1 = pull ps2d low; 0 = release
tx_busy  out  1  high from accept until return to idle
tx_done_tick  out  1  one-cycle pulse: device ACKed the frame
tx_err_tick  out  1  one-cycle pulse: NACK or timeout

Behaviour:
- Reset: state=idle; ps2c_oe=0, ps2d_oe=0, tx_busy=0, both ticks=0; counters cleared. Reset mid-frame releases both lines on the next clk edge.
- ps2c_in path: 2-FF synchroniser, then FILTER_LEN-sample filter. fall = filtered level goes 1->0; it is a one-cycle pulse.
- Frame shift register (9 bits): {odd parity = ~^din, din}, loaded on accept and shifted LSB-first.
- States:
  - idle: tx_busy=0. If wr_ps2=1, load din and go to rts on the next cycle.
  - rts: ps2c_oe=1 for exactly INHIBIT_CYC cycles, then go to req.
  - req: ps2c_oe=1 and ps2d_oe=1 for 1 cycle (start bit), then go to start. Clear the timeout counter.
  - start: ps2c_oe=0, ps2d_oe=1. On fall, drive bit0 (ps2d_oe = ~bit) and go to data.
  - data: on each fall, drive the next bit. After parity has been driven (falls 1..9 total), the next fall (10) releases ps2d (stop bit) and goes to ack.
  - ack: on fall 11, sample filtered ps2d_in. 0 = ACK, 1 = NACK. Either way go to release.
  - release: wait until filtered ps2c=1 and ps2d_in=1, then return to idle. Pulse tx_done_tick on ACK or tx_err_tick on NACK, in the same cycle as the idle transition.
- Timeout: the counter runs in start/data/ack/release. Reaching TIMEOUT_CYC: tx_err_tick=1, both oe=0, go to idle.
- While tx_busy=1, wr_ps2 is ignored and din changes have no effect.
- wr_ps2 in the same cycle as reset: reset wins.
- tx_done_tick and tx_err_tick are never high in the same cycle.
- Outputs are Moore-decoded from the registered state plus the shift register LSB. No combinational path from inputs to outputs.

Decomposition:
- ps2_pkg holds:
  - state encoding localparams
  - command constants PS2_CMD_SET_LEDS=8'hED, PS2_CMD_RESET=8'hFF, PS2_ACK=8'hFA, PS2_BREAK=8'hF0
  - default INHIBIT_CYC and TIMEOUT_CYC
- Sub-module ps2_clk_filter (synchroniser + filter + fall pulse). It is shared with the receive path.

Test Plan:
- Reset then idle -> ps2c_oe=0, ps2d_oe=0, tx_busy=0, no ticks for 100 cycles.
- wr_ps2 with din=8'hED and a device model ACKing -> ps2c_oe high for exactly 5000 cycles. Device samples on rising edges: start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1. After fall 11 and release: tx_done_tick for one cycle, tx_busy=0.
- Same frame, device leaves ps2d high at clock 11 -> tx_err_tick=1 for one cycle, tx_done_tick never asserted.
- Device never clocks -> tx_err_tick exactly TIMEOUT_CYC cycles after leaving req; both oe=0; next wr_ps2 with 8'hFF completes normally.
- wr_ps2 with din=8'h00 asserted during data state of an 8'hED frame -> ignored; transmitted bits still match 8'hED.
- reset asserted at data bit 4 -> next cycle ps2c_oe=0, ps2d_oe=0, tx_busy=0. A 3-cycle low glitch on ps2c during data is not counted as a fall.
